// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data and memory-side signals of the shared memory arbiter
`ifndef MEM_MODE_BYTE
`define MEM_MODE_BYTE  2'd0
`define MEM_MODE_HWORD 2'd1
`define MEM_MODE_WORD  2'd2
`endif

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_mode;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_done;
    logic              d_err;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-3:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_ready;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_done, d_rdata, d_done, d_err, m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_done, d_rdata, d_done, d_err, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port word memory between instruction fetch and load/store
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic rst_n,
    mem_bus_arbiter_if.master bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, IF_RD, D_RD, D_WR, RMW_RD, RMW_WR, RESP_IF, RESP_D} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lo;
    logic [1:0]    mode;
    logic [31:0]   wdata;
    logic          is_word;
    logic          mis;
    logic          d_pick;
    logic          unused_bits;

    assign unused_bits = ^bus.if_addr[1:0];

    // Extract the addressed byte/halfword lane, zero-extended
    function automatic logic [31:0] load_lane(logic [31:0] w, logic [1:0] m, logic [1:0] a);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        return m == `MEM_MODE_BYTE ? {24'b0, s[7:0]} : m == `MEM_MODE_HWORD ? {16'b0, s[15:0]} : w;
    endfunction

    // Replace the addressed lane of the old word with the low store bits
    function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d, logic [1:0] m, logic [1:0] a);
        logic [31:0] mask;
        mask = (m == `MEM_MODE_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << {a, 3'b000};
        return (w & ~mask) | ((d << {a, 3'b000}) & mask);
    endfunction

    // Alignment check and data-vs-fetch decision on the live request inputs
    always_comb begin
        is_word = bus.d_mode != `MEM_MODE_HWORD && bus.d_mode != `MEM_MODE_BYTE;
        mis     = is_word ? |bus.d_addr[1:0] : bus.d_mode == `MEM_MODE_HWORD ? bus.d_addr[0] : 1'b0;
        d_pick  = bus.d_req && !(bus.if_req && cnt == CW'(STARVE_MAX));
    end

    // Arbiter FSM: grants, holds the memory strobe until ready, registers every response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lo           <= '0;
            mode         <= '0;
            wdata        <= '0;
            bus.if_rdata <= '0;
            bus.if_done  <= 1'b0;
            bus.d_rdata  <= '0;
            bus.d_done   <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.m_en     <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_pick) begin
                        cnt   <= bus.if_req ? (cnt == CW'(STARVE_MAX) ? cnt : cnt + 1'b1) : '0;
                        lo    <= bus.d_addr[1:0];
                        mode  <= bus.d_mode;
                        wdata <= bus.d_wdata;
                        if (mis) begin
                            state       <= RESP_D;
                            bus.d_done  <= 1'b1;
                            bus.d_err   <= 1'b1;
                            bus.d_rdata <= '0;
                        end else begin
                            bus.m_en   <= 1'b1;
                            bus.m_addr <= bus.d_addr[ADDR_W-1:2];
                            if (!bus.d_we) begin
                                state <= D_RD;
                            end else if (is_word) begin
                                state       <= D_WR;
                                bus.m_we    <= 1'b1;
                                bus.m_wdata <= bus.d_wdata;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end else if (bus.if_req) begin
                        cnt        <= '0;
                        state      <= IF_RD;
                        bus.m_en   <= 1'b1;
                        bus.m_addr <= bus.if_addr[ADDR_W-1:2];
                    end
                end
                IF_RD: if (bus.m_ready) begin
                    state        <= RESP_IF;
                    bus.m_en     <= 1'b0;
                    bus.if_rdata <= bus.m_rdata;
                    bus.if_done  <= 1'b1;
                end
                D_RD: if (bus.m_ready) begin
                    state       <= RESP_D;
                    bus.m_en    <= 1'b0;
                    bus.d_rdata <= load_lane(bus.m_rdata, mode, lo);
                    bus.d_done  <= 1'b1;
                end
                RMW_RD: if (bus.m_ready) begin
                    state       <= RMW_WR;
                    bus.m_we    <= 1'b1;
                    bus.m_wdata <= merge(bus.m_rdata, wdata, mode, lo);
                end
                D_WR, RMW_WR: if (bus.m_ready) begin
                    state       <= RESP_D;
                    bus.m_en    <= 1'b0;
                    bus.m_we    <= 1'b0;
                    bus.m_wdata <= '0;
                    bus.d_done  <= 1'b1;
                end
                RESP_IF: begin
                    state       <= IDLE;
                    bus.if_done <= 1'b0;
                end
                RESP_D: begin
                    state      <= IDLE;
                    bus.d_done <= 1'b0;
                    bus.d_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, word-wide, zero-or-more-wait-state memory between the instruction-fetch path and the data path (lw/lbu/lhu/sw/sb/sh).
- Performs byte/halfword lane selection for loads and read-modify-write for sub-word stores; the memory has no byte enables.
- Sits between the core's fetch/load-store stages and the memory model.
- Data port fields come directly from the decoder's mem_read/mem_write/mem_acc_mode outputs.

Parameters:
- ADDR_W, 32, byte-address width on both requester ports.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level; held with if_addr stable until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- d_req  in  1  data request, level; held with all d_* inputs stable until d_done
- d_we  in  1  1=store, 0=load
- d_mode  in  2  access size, encoded per MEM_MODE_WORD/HWORD/BYTE defines
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data; byte store uses [7:0], hword store uses [15:0]
- d_rdata  out  32  zero-extended load result, valid while d_done=1
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  misalignment flag, valid with d_done
- m_en  out  1  memory access strobe, held until m_ready
- m_we  out  1  memory write when m_en=1
- m_addr  out  ADDR_W-2  word address (byte address [ADDR_W-1:2])
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid when m_ready=1
- m_ready  in  1  memory completes the current access in this cycle

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, starvation counter=0.
  - All outputs 0, including m_en; an access in progress is abandoned.
- States and transitions:
  - IDLE: arbitrate. Misaligned data request → RESP_D. Word store → D_WR. Sub-word store → RMW_RD. Load → D_RD. Fetch → IF_RD.
  - IF_RD, D_RD, D_WR, RMW_RD, RMW_WR: m_en=1, m_addr from the granted address.
  - Exit on a cycle with m_ready=1:
    - IF_RD → RESP_IF
    - D_RD → RESP_D
    - D_WR → RESP_D
    - RMW_RD → RMW_WR; latch the merged word
    - RMW_WR → RESP_D
  - RESP_IF / RESP_D: if_done or d_done=1 with registered data, then IDLE.
- Latency:
  - Zero-wait memory (m_ready high in the first m_en cycle): req in IDLE at cycle 0, access at cycle 1, done at cycle 2.
  - Sub-word store: done at cycle 3.
  - Each wait cycle adds one.
  - Misaligned request: done at cycle 1, no memory access.
- Back-to-back:
  - Requesters may present a new request the cycle after done.
  - IDLE re-arbitrates then; there is no lost cycle beyond IDLE.
- Arbitration:
  - Data has priority over fetch.
  - The counter increments on each data grant made while if_req=1.
  - The counter clears on a fetch grant, or on a data grant made while if_req=0.
  - If the counter equals STARVE_MAX and both requests are pending, fetch wins.
  - The counter saturates at STARVE_MAX.
- Alignment:
  - WORD requires addr[1:0]=0.
  - HWORD requires addr[0]=0.
  - BYTE is always aligned.
  - On violation: d_err=1, d_rdata=0, no memory write.
- Loads (little-endian, byte 0 = bits[7:0]):
  - BYTE: d_rdata = {24'b0, m_rdata[8*addr[1:0]+:8]}.
  - HWORD: d_rdata = {16'b0, m_rdata[16*addr[1]+:16]}.
  - WORD: d_rdata = m_rdata.
- Sub-word store:
  - RMW_RD reads the word.
  - The merge replaces the addressed lane with d_wdata low bits and keeps the other bytes.
  - RMW_WR writes the merged word with m_we=1.
- m_we is 1 only in D_WR and RMW_WR.
- m_wdata is 0 when m_we=0.
- if_rdata and d_rdata hold their last value outside done cycles; only done qualifies them.
- d_err=0 whenever d_done=0.
- A request dropped mid-access without reset is illegal; the block completes the access and still pulses done.

Test Plan:
- Fetch, zero-wait: if_addr=0x100, memory word 0x100=0x8C010004 → m_en cycle 1 with m_addr=0x40; if_done cycle 2 with if_rdata=0x8C010004.
- Load byte/hword: word@0x200=0xAABBCCDD.
  - BYTE addr 0x201 → d_rdata=0x000000CC.
  - HWORD addr 0x202 → d_rdata=0x0000AABB.
  - 2 wait states → d_done at cycle 4.
- Sub-word store: word@0x300=0x11223344; sb addr 0x302, d_wdata=0xFFFFFF5A → read then write 0x115A3344; sh addr 0x300, d_wdata=0xBEEF → 0x1122BEEF.
- Misaligned: lw addr 0x203, and sh addr 0x301 → d_done+d_err at cycle 1, d_rdata=0, m_en never asserted.
- Arbitration: if_req and d_req both held continuously with STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF.
- Reset: assert rst_n=0 mid RMW_RD → m_en, m_we, done outputs drop immediately; after release the state is IDLE and no write occurs.
